// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FWFT FIFO consumer that serialises words onto a UART line (optional parity: FIFO_UART_TX_PARITY_EN)
module fifo_uart_tx #(
  parameter int B            = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_r_data,
  output logic         fifo_rd,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done_tick
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            IW        = $clog2(B);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(B - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [IW-1:0] bit_idx;
  logic          stop_idx;
  logic [B-1:0]  shreg;
  logic          bit_end;
  logic          frame_end;
  logic          pop;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          par;
`endif

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign frame_end = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  // Reset is folded in so the FIFO is never popped while the transmitter is held in reset.
  assign pop       = reset_n && en && !fifo_empty && ((state == IDLE) || frame_end);
  assign fifo_rd   = pop;

  // Frame sequencer: a pop always restarts at START, so back-to-back frames have no idle gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      // Done is raised one cycle early so that it is high exactly in the final stop-bit cycle.
      tx_done_tick <= (state == STOP) && (stop_idx == STOP_LAST) && (baud_cnt == CNT_PRE);
      if (pop) begin
        state    <= START;
        shreg    <= fifo_r_data;
        baud_cnt <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        tx       <= 1'b0;
        tx_busy  <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        par      <= ^fifo_r_data;
`endif
      end else begin
        case (state)
          IDLE: begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
          START: begin
            if (bit_end) begin
              state    <= DATA;
              baud_cnt <= '0;
              tx       <= shreg[0];
            end else begin
              baud_cnt <= baud_cnt + CNT_ONE;
            end
          end
          DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_idx == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                state <= PARITY;
                tx    <= par;
`else
                state <= STOP;
                tx    <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + IDX_ONE;
                shreg   <= shreg >> 1;
                tx      <= shreg[1];
              end
            end else begin
              baud_cnt <= baud_cnt + CNT_ONE;
            end
          end
`ifdef FIFO_UART_TX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              state    <= STOP;
              baud_cnt <= '0;
              tx       <= 1'b1;
            end else begin
              baud_cnt <= baud_cnt + CNT_ONE;
            end
          end
`endif
          STOP: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (stop_idx == STOP_LAST) begin
                state    <= IDLE;
                stop_idx <= 1'b0;
                tx       <= 1'b1;
                tx_busy  <= 1'b0;
              end else begin
                stop_idx <= stop_idx + 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx with a FIFO model and a line-level receiver model
module tb_fifo_uart_tx;

  localparam int B   = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int NBITS = 1 + B + PB + SB;
  localparam int FRAME = NBITS * CPB;

  typedef struct {
    logic [B-1:0] word;
    int           pop_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [B-1:0] fifo_r_data = '0;
  logic         fifo_rd;
  logic         tx;
  logic         tx_busy;
  logic         tx_done_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rx_cnt   = -1;
  int frames   = 0;

  logic [B-1:0] fifo_q[$];
  exp_t         exp_q[$];

  fifo_uart_tx #(.B(B), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .fifo_empty(fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Expected line levels of one frame, index 0 = start bit.
  function automatic logic [NBITS-1:0] build(input logic [B-1:0] w);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < B; i++) f[1 + i] = w[i];
`ifdef FIFO_UART_TX_PARITY_EN
    f[1 + B] = ^w;
`endif
    return f;
  endfunction

  // Monitor / scoreboard: models when a pop must occur and what the line must show.
  initial begin
    exp_t             e;
    logic [NBITS-1:0] frame_bits;
    logic             last;
    logic             idle;
    logic             exp_pop;
    frame_bits = '1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done_tick, 0);
        check("rst_rd", fifo_rd, 0);
        rx_cnt = -1;
        exp_q.delete();
        continue;
      end
      if (rx_cnt < 0 && tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("start_latency", cyc, e.pop_cyc + 1);
          frame_bits = build(e.word);
          rx_cnt = 0;
        end
      end
      last    = (rx_cnt == FRAME - 1);
      idle    = (rx_cnt < 0) && (exp_q.size() == 0);
      exp_pop = en && !fifo_empty && (idle || last);
      check("fifo_rd", fifo_rd, exp_pop);
      if (fifo_rd && fifo_empty) check("rd_while_empty", 1, 0);
      if (exp_pop) begin
        e.word    = fifo_r_data;
        e.pop_cyc = cyc;
        exp_q.push_back(e);
      end
      if (rx_cnt >= 0) begin
        check("tx_bit", tx, frame_bits[rx_cnt / CPB]);
        check("busy", tx_busy, 1);
        check("done_tick", tx_done_tick, last);
        if (last) begin
          frames++;
          rx_cnt = -1;
        end else begin
          rx_cnt++;
        end
      end else begin
        check("idle_tx", tx, 1);
        check("idle_busy", tx_busy, 0);
        check("idle_done", tx_done_tick, 0);
      end
    end
  end

  function automatic void refresh();
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = fifo_empty ? '0 : fifo_q[0];
  endfunction

  task automatic push(input logic [B-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // One clock of the FIFO model: a strobe seen this cycle removes the head after the edge.
  task automatic step();
    logic rd_s;
    @(negedge clk);
    rd_s = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && rx_cnt < 0 && exp_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    check(name, n < budget, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Single frame 0xA5.
    en = 1'b1;
    push(8'hA5);
    drain("drain_single", 3 * FRAME);
    check("frames_single", frames, 1);
    repeat (3) step();

    // Back-to-back 0x00, 0xFF.
    push(8'h00);
    push(8'hFF);
    drain("drain_b2b", 4 * FRAME);
    check("frames_b2b", frames, 3);

    // Empty FIFO for 100 cycles.
    repeat (100) step();
    check("frames_empty", frames, 3);

    // Disabled with data waiting, then enable, then drop enable mid-frame.
    en = 1'b0;
    push(8'h3C);
    repeat (20) step();
    check("no_pop_disabled", fifo_q.size(), 1);
    en = 1'b1;
    step();
    push(8'h55);
    repeat (12) step();
    en = 1'b0;
    repeat (FRAME + 10) step();
    check("frames_en_drop", frames, 4);
    check("kept_count", fifo_q.size(), 1);
    check("kept_word", fifo_q.size() > 0 ? int'(fifo_q[0]) : -1, 'h55);
    en = 1'b1;
    drain("drain_55", 3 * FRAME);
    check("frames_55", frames, 5);

    // Asynchronous reset in the middle of a frame.
    push(8'h96);
    push(8'h4B);
    n = 0;
    while (rx_cnt < 20 && n < 3 * FRAME) begin
      step();
      n++;
    end
    check("reach_mid_frame", rx_cnt, 20);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_tx", tx, 1);
    check("async_busy", tx_busy, 0);
    step();
    step();
    reset_n = 1'b1;
    f0 = frames;
    drain("drain_after_reset", 3 * FRAME);
    check("frames_after_reset", frames - f0, 1);
    check("fifo_after_reset", fifo_q.size(), 0);

    // Randomised traffic with enable toggling.
    n = 0;
    for (int i = 0; i < 4000 && n < 40; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 20) == 0) begin
        push(B'($urandom));
        n++;
      end
      step();
    end
    en = 1'b1;
    drain("drain_random", 50 * FRAME);
    check("random_pushed", n, 40);
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Pops words from a first-word-fall-through FIFO read port (rd / empty / r_data) and serialises each one onto a UART line: 8N1 by default, LSB first.
- Sits between the TX FIFO and the board pin. Frames go out back-to-back while the FIFO holds data and the block is enabled.

Parameters:
- B, 8, data bits per word and per frame (5..9).
- CLKS_PER_BIT, 868, clk cycles per UART bit (the default gives 115200 baud at 100 MHz); must be >= 2.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  transmit enable; sampled only when a new frame could start.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_data  input  B  FIFO head word; valid whenever fifo_empty=0.
- fifo_rd  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- tx_done_tick  output  1  one-cycle pulse in the last cycle of each frame.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, fifo_rd=0.
  - Baud counter, bit index and shift register cleared.
  - Takes effect immediately, including mid-frame. The byte being sent is discarded and never re-popped.
- States: IDLE, START, DATA, STOP, plus PARITY when enabled. tx is driven from a register (no glitches).
- Pop condition: pop = en & ~fifo_empty & (state==IDLE | last cycle of last stop bit).
  - fifo_rd = pop, combinational (Mealy), so it is exactly one cycle per word.
  - In the same cycle, fifo_r_data is captured into the shift register.
  - fifo_rd is never asserted while fifo_empty=1.
- Latency: tx goes low in the cycle after the fifo_rd pulse.
- Bit timing: every bit lasts exactly CLKS_PER_BIT cycles, counted by a baud counter of width clog2(CLKS_PER_BIT) that runs 0..CLKS_PER_BIT-1.
- Bit order per frame:
  - START: tx=0.
  - DATA: B bits, LSB first; shift right at each bit boundary.
  - STOP: STOP_BITS x tx=1.
- Frame end (last cycle of the last stop bit):
  - tx_done_tick=1 for that cycle.
  - If pop is true: go to START with the new word. This gives zero idle cycles between frames, so frame period = (1+B+STOP_BITS)*CLKS_PER_BIT.
  - Otherwise: go to IDLE.
- en deasserted mid-frame: the current frame completes normally; no further pops.
- fifo_empty rising mid-frame: no effect on the current frame.
- tx_busy=1 in START, DATA, STOP (and PARITY); 0 in IDLE.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the B data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 1+B+1+STOP_BITS bits.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
- Single byte (B=8, CLKS_PER_BIT=4, STOP_BITS=1, en=1):
  - Stimulus: FIFO holds 0xA5.
  - Response: one fifo_rd pulse. Next cycle, tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). tx_done_tick in cycle 40. Then tx=1, tx_busy=0.
- Back-to-back:
  - Stimulus: FIFO holds 0x00, 0xFF.
  - Response: fifo_rd pulses exactly 40 cycles apart; no idle-high gap between the frames. Line shows start, eight 0s, stop, start, eight 1s, stop. Exactly two pops.
- Empty / disabled:
  - Stimulus A: fifo_empty=1 for 100 cycles. Response: fifo_rd never 1, tx=1.
  - Stimulus B: en=0 with FIFO holding 0x3C. Response: no pop.
  - Stimulus C: then raise en. Response: pop on the same cycle.
- en drop mid-frame:
  - Stimulus: deassert en at cycle 12 of the 0x3C frame, with 0x55 queued.
  - Response: the 0x3C frame completes (40 cycles); 0x55 is not popped and stays in the FIFO.
- Async reset:
  - Stimulus: drive reset_n low at cycle 20 of a frame, between clock edges.
  - Response: tx=1 and tx_busy=0 before the next edge. After release with the FIFO non-empty, the next word is popped on the first enabled cycle.
- Parity (FIFO_UART_TX_PARITY_EN defined):
  - Stimulus: send 0xA5, then 0x01.
  - Response: parity bit is 0 for 0xA5 and 1 for 0x01. Each frame is 44 cycles; tx_done_tick occurs at cycle 44.
